// File: rtl/interrupt_priority_ctrl_pkg.sv
// Shared defaults and helpers for the interrupt priority controller and the
// per-line samplers that feed it.
package interrupt_priority_ctrl_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned ID_W_DEF    = 2;
  localparam int unsigned MAX_SRC     = 32;

  // Bits strictly below the lowest set bit of v; all ones when v is zero.
  function automatic logic [MAX_SRC-1:0] below_lowest(input logic [MAX_SRC-1:0] v);
    return (v & (~v + MAX_SRC'(1))) - MAX_SRC'(1);
  endfunction

endpackage

// File: rtl/interrupt_priority_ctrl_prio_enc_lsb.sv
// Priority encoder: reports whether any bit is set and the index of the
// lowest set bit (0 when none).
module prio_enc_lsb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] in,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in[i] && !valid) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_priority_ctrl.sv
// Masks and prioritises sampler indications, issues a registered request to
// the CPU, and tracks nested in-service levels across ack/eret.
module interrupt_priority_ctrl
  import interrupt_priority_ctrl_pkg::*;
#(
  parameter int unsigned         NUM_SRC  = NUM_SRC_DEF,
  parameter int unsigned         ID_W     = ID_W_DEF,
  parameter logic [NUM_SRC-1:0]  MASK_RST = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] indication,
  input  logic               global_en,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  input  logic               int_eret,
  output logic [NUM_SRC-1:0] clr,
  output logic [NUM_SRC-1:0] isr
);

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [NUM_SRC-1:0] clr_q, clr_d;
  logic               int_req_q, int_req_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;

  logic               isr_valid;
  logic [ID_W-1:0]    isr_lo_idx;
  logic [NUM_SRC-1:0] eligible;
  logic               elig_valid;
  logic [ID_W-1:0]    elig_idx;
  logic [NUM_SRC-1:0] ceiling;
  logic [NUM_SRC-1:0] ack_vec;
  logic               ack_ok;

  // Eret target: lowest in-service index of the current (old) isr.
  prio_enc_lsb #(.N(NUM_SRC), .W(ID_W)) u_isr_enc (
    .in    (isr_q),
    .valid (isr_valid),
    .idx   (isr_lo_idx)
  );

  prio_enc_lsb #(.N(NUM_SRC), .W(ID_W)) u_elig_enc (
    .in    (eligible),
    .valid (elig_valid),
    .idx   (elig_idx)
  );

  always_comb begin
    mask_d  = mask_we ? mask_wdata : mask_q;
    ack_ok  = int_ack && int_req_q;
    ack_vec = ack_ok ? (NUM_SRC'(1) << int_id_q) : '0;

    // Eret retires from the old isr first, so a same-cycle ack bit survives.
    isr_d = isr_q;
    if (int_eret && isr_valid) begin
      isr_d[isr_lo_idx] = 1'b0;
    end
    isr_d = isr_d | ack_vec;
    clr_d = ack_vec;

    // Priority ceiling is taken from isr_d directly as a bit mask.
    ceiling  = NUM_SRC'(below_lowest(MAX_SRC'(isr_d)));
    eligible = indication & ~mask_d & ~isr_d & ceiling;

    int_req_d = global_en && elig_valid;
    int_id_d  = elig_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= MASK_RST;
      isr_q     <= '0;
      clr_q     <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      mask_q    <= mask_d;
      isr_q     <= isr_d;
      clr_q     <= clr_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  assign mask    = mask_q;
  assign isr     = isr_q;
  assign clr     = clr_q;
  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_interrupt_priority_ctrl.sv
// Directed self-checking bench for interrupt_priority_ctrl with a queue of
// hand-derived expected register states.
module tb_interrupt_priority_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] indication;
  logic       global_en;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic       int_req;
  logic [1:0] int_id;
  logic       int_ack;
  logic       int_eret;
  logic [3:0] clr;
  logic [3:0] isr;

  typedef struct {
    string      tag;
    logic [3:0] mask;
    logic [3:0] isr;
    logic       req;
    logic [1:0] id;
    logic [3:0] clr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  interrupt_priority_ctrl #(
    .NUM_SRC  (4),
    .ID_W     (2),
    .MASK_RST (4'b1111)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .indication (indication),
    .global_en  (global_en),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .int_eret   (int_eret),
    .clr        (clr),
    .isr        (isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // pop and compare it #1 after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] ind, input logic gen,
                      input logic mwe, input logic [3:0] mwd, input logic ack, input logic eret,
                      input logic [3:0] e_mask, input logic [3:0] e_isr, input logic e_req,
                      input logic [1:0] e_id, input logic [3:0] e_clr);
    exp_t e;
    rst = r; indication = ind; global_en = gen; mask_we = mwe; mask_wdata = mwd;
    int_ack = ack; int_eret = eret;
    exp_q.push_back('{tag, e_mask, e_isr, e_req, e_id, e_clr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(e.tag, "mask", mask, e.mask);
    chk(e.tag, "isr", isr, e.isr);
    chk(e.tag, "int_req", {3'b0, int_req}, {3'b0, e.req});
    chk(e.tag, "int_id", {2'b0, int_id}, {2'b0, e.id});
    chk(e.tag, "clr", clr, e.clr);
  endtask

  initial begin
    rst = 1'b1; indication = '0; global_en = 1'b0; mask_we = 1'b0;
    mask_wdata = '0; int_ack = 1'b0; int_eret = 1'b0;
    //    tag         rst ind     gen mwe wdata   ack eret  mask    isr     req id     clr
    step("reset",     1, 4'b0000, 0, 0, 4'b0000, 0, 0,   4'b1111, 4'b0000, 0, 2'd0, 4'b0000);
    step("masked",    0, 4'b0100, 1, 0, 4'b0000, 0, 0,   4'b1111, 4'b0000, 0, 2'd0, 4'b0000);
    step("unmask",    0, 4'b0100, 1, 1, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd2, 4'b0000);
    step("pick1",     0, 4'b1010, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd1, 4'b0000);
    step("ack1",      0, 4'b1010, 1, 0, 4'b0000, 1, 0,   4'b0000, 4'b0010, 0, 2'd0, 4'b0010);
    step("clrlat",    0, 4'b1010, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0010, 0, 2'd0, 4'b0000);
    step("ceil3",     0, 4'b1000, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0010, 0, 2'd0, 4'b0000);
    step("eret1",     0, 4'b1000, 1, 0, 4'b0000, 0, 1,   4'b0000, 4'b0000, 1, 2'd3, 4'b0000);
    step("pick2",     0, 4'b0100, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd2, 4'b0000);
    step("ack2",      0, 4'b0100, 1, 0, 4'b0000, 1, 0,   4'b0000, 4'b0100, 0, 2'd0, 4'b0100);
    step("low_blk",   0, 4'b1000, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0100, 0, 2'd0, 4'b0000);
    step("nest_req",  0, 4'b1001, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0100, 1, 2'd0, 4'b0000);
    step("nest_ack",  0, 4'b1001, 1, 0, 4'b0000, 1, 0,   4'b0000, 4'b0101, 0, 2'd0, 4'b0001);
    step("nest_ret0", 0, 4'b1000, 1, 0, 4'b0000, 0, 1,   4'b0000, 4'b0100, 0, 2'd0, 4'b0000);
    step("nest_ret2", 0, 4'b1000, 1, 0, 4'b0000, 0, 1,   4'b0000, 4'b0000, 1, 2'd3, 4'b0000);
    step("hold3",     0, 4'b1000, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd3, 4'b0000);
    step("pick2b",    0, 4'b0100, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd2, 4'b0000);
    step("ack2b",     0, 4'b0100, 1, 0, 4'b0000, 1, 0,   4'b0000, 4'b0100, 0, 2'd0, 4'b0100);
    step("pick1b",    0, 4'b0010, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0100, 1, 2'd1, 4'b0000);
    step("ack_eret",  0, 4'b0010, 1, 0, 4'b0000, 1, 1,   4'b0000, 4'b0010, 0, 2'd0, 4'b0010);
    step("idle",      0, 4'b0000, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0010, 0, 2'd0, 4'b0000);
    step("eret_last", 0, 4'b0000, 1, 0, 4'b0000, 0, 1,   4'b0000, 4'b0000, 0, 2'd0, 4'b0000);
    step("spurious",  0, 4'b0000, 1, 0, 4'b0000, 1, 1,   4'b0000, 4'b0000, 0, 2'd0, 4'b0000);
    step("pick0",     0, 4'b0001, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd0, 4'b0000);
    step("gen_off",   0, 4'b0001, 0, 0, 4'b0000, 1, 0,   4'b0000, 4'b0001, 0, 2'd0, 4'b0001);
    step("gen_on",    0, 4'b0000, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0001, 0, 2'd0, 4'b0000);
    step("eret0",     0, 4'b0000, 1, 0, 4'b0000, 0, 1,   4'b0000, 4'b0000, 0, 2'd0, 4'b0000);
    step("pick2c",    0, 4'b0100, 1, 0, 4'b0000, 0, 0,   4'b0000, 4'b0000, 1, 2'd2, 4'b0000);
    step("mask2",     0, 4'b0100, 1, 1, 4'b0100, 0, 0,   4'b0100, 4'b0000, 0, 2'd0, 4'b0000);
    step("pick1c",    0, 4'b0110, 1, 0, 4'b0000, 0, 0,   4'b0100, 4'b0000, 1, 2'd1, 4'b0000);
    step("ack1c",     0, 4'b0101, 1, 0, 4'b0000, 1, 0,   4'b0100, 4'b0010, 1, 2'd0, 4'b0010);
    step("ack0c",     0, 4'b0101, 1, 0, 4'b0000, 1, 0,   4'b0100, 4'b0011, 0, 2'd0, 4'b0001);
    step("rst_mid",   1, 4'b1111, 1, 1, 4'b0000, 1, 1,   4'b1111, 4'b0000, 0, 2'd0, 4'b0000);
    step("post_rst",  0, 4'b1111, 1, 0, 4'b0000, 0, 0,   4'b1111, 4'b0000, 0, 2'd0, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
